// File: rtl/masked_rank_select.sv
// masked_rank_select: sliding window of N samples. Every accepted sample shifts
// into the window. Once the window is full, the cycle after an accept looks at
// the externally supplied per-slot ranks, the mask and the target. It then
// returns the sample in the lowest masked slot whose rank equals the target,
// or raises out_err if no slot matches. At most one result is in flight.
//
// Ports
//   clk, rst    : single clock, synchronous active-high reset
//   in_valid    : a new sample is offered
//   in_ready    : the block can accept a sample this cycle
//   in_sample   : offered sample (W bits)
//   shift_en    : in_valid & in_ready; advances the upstream rank matrix
//   ranks       : masked rank per slot, slot j at [j*RB +: RB]
//   mask        : bit j set = slot j participates
//   target      : requested order statistic (1 = smallest)
//   out_valid   : result valid, held until out_ready
//   out_ready   : consumer accepts the result
//   out_sample  : selected sample (0 on error)
//   out_err     : no masked slot matched the target
module masked_rank_select #(
  parameter int unsigned N = 7,
  parameter int unsigned W = 8,
  localparam int unsigned RB = $clog2(N + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_sample,
  output logic            shift_en,
  input  logic [RB*N-1:0] ranks,
  input  logic [N-1:0]    mask,
  input  logic [RB-1:0]   target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_sample,
  output logic            out_err
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]  win [N];
  logic [RB-1:0] fill_cnt;
  logic [RB-1:0] fill_next;
  logic          s1_valid;
  logic          hit;
  logic [IW-1:0] hit_idx;

  // Only one result may be in flight; the output slot must be free or draining.
  assign in_ready = !s1_valid && (!out_valid || out_ready);
  assign shift_en = in_valid && in_ready;

  // Fill count after this accept, saturating at N.
  always_comb begin
    fill_next = fill_cnt;
    if (fill_cnt != RB'(N)) begin
      fill_next = fill_cnt + RB'(1);
    end
  end

  // Lowest matching slot: scan downwards so the lowest index wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (mask[j] && (ranks[j*int'(RB) +: RB] == target)) begin
        hit     = 1'b1;
        hit_idx = IW'(j);
      end
    end
  end

  // Sample window: slot N-1 is the newest sample, slot 0 the oldest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < int'(N); j++) begin
        win[j] <= '0;
      end
    end else if (shift_en) begin
      for (int j = 0; j < int'(N) - 1; j++) begin
        win[j] <= win[j+1];
      end
      win[N-1] <= in_sample;
    end
  end

  // Warm-up counter and selection stage flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt <= '0;
      s1_valid <= 1'b0;
    end else begin
      if (shift_en) begin
        fill_cnt <= fill_next;
      end
      // in_ready excludes s1_valid, so an accept never coincides with stage 1.
      s1_valid <= shift_en && (fill_next == RB'(N));
    end
  end

  // Result register: a new load wins over a consumer drain on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sample <= '0;
      out_err    <= 1'b0;
    end else if (s1_valid) begin
      out_valid  <= 1'b1;
      out_sample <= hit ? win[hit_idx] : '0;
      out_err    <= !hit;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_masked_rank_select.sv
// Randomized and directed bench for masked_rank_select (N=7, W=8) against a
// cycle-level behavioural reference model.
module tb_masked_rank_select;

  localparam int unsigned N  = 7;
  localparam int unsigned W  = 8;
  localparam int unsigned RB = $clog2(N + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_sample;
  logic            shift_en;
  logic [RB*N-1:0] ranks;
  logic [N-1:0]    mask;
  logic [RB-1:0]   target;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_sample;
  logic            out_err;

  masked_rank_select #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
    .shift_en(shift_en), .ranks(ranks), .mask(mask), .target(target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sample(out_sample), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: the window as a plain array, a fill count, whether
  // the last cycle was a full-window accept, and the pending output.
  int          m_win [N];
  int          m_fill   = 0;
  bit          m_sel    = 0;
  bit          m_ov     = 0;
  int          m_sample = 0;
  bit          m_err    = 0;
  int          m_acc    = 0;
  int          m_res_cnt = 0;
  bit          chk_on   = 0;

  // Lowest masked slot whose rank equals the target; -1 if none.
  function automatic int pick(input logic [RB*N-1:0] r, input logic [N-1:0] m,
                              input logic [RB-1:0] t);
    logic [RB-1:0] rk;
    for (int j = 0; j < int'(N); j++) begin
      rk = r[j*int'(RB) +: RB];
      if (m[j] && rk == t) return j;
    end
    return -1;
  endfunction

  // Checks at the falling edge, then advance the model by one cycle.
  always @(negedge clk) begin
    bit exp_ready;
    bit acc;
    int k;
    exp_ready = !m_sel && (!m_ov || out_ready);
    acc       = in_valid && exp_ready;
    if (chk_on) begin
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("shift_en", 32'(shift_en), 32'(acc));
      if (m_ov) begin
        check("out_sample", 32'(out_sample), 32'(m_sample));
        check("out_err", 32'(out_err), 32'(m_err));
      end
    end
    if (rst) begin
      for (int j = 0; j < int'(N); j++) m_win[j] = 0;
      m_fill = 0; m_sel = 0; m_ov = 0; m_sample = 0; m_err = 0;
    end else begin
      if (m_ov && out_ready) m_res_cnt++;
      if (m_sel) begin
        k = pick(ranks, mask, target);
        m_ov     = 1;
        m_err    = (k < 0);
        m_sample = (k < 0) ? 0 : m_win[k];
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      m_sel = 0;
      if (acc) begin
        m_acc++;
        for (int j = 0; j < int'(N) - 1; j++) m_win[j] = m_win[j+1];
        m_win[N-1] = int'(in_sample);
        if (m_fill < int'(N)) m_fill++;
        m_sel = (m_fill == int'(N));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ranks_seq();
    for (int j = 0; j < int'(N); j++) ranks[j*int'(RB) +: RB] = RB'(j + 1);
  endtask

  task automatic randomize_inputs();
    in_valid  = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 3) != 0);
    in_sample = W'($urandom);
    mask      = N'($urandom);
    target    = RB'($urandom_range(0, N));
    for (int j = 0; j < int'(N); j++) ranks[j*int'(RB) +: RB] = RB'($urandom_range(0, N));
    rst       = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    int a0;
    int r0;
    for (int j = 0; j < int'(N); j++) m_win[j] = 0;
    rst = 1; in_valid = 0; in_sample = '0; out_ready = 1;
    mask = '1; target = RB'(4); ranks = '0;
    set_ranks_seq();
    step(); step();
    rst = 0;
    chk_on = 1;
    check("ready_after_reset", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);

    // Warm-up with window 10..70 and sequential ranks, target 4.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1; in_sample = W'(10 * (i + 1));
      step();
      check("warmup_no_out", 32'(out_valid), 32'd0);
    end
    in_valid = 0;
    step();
    check("sel_valid", 32'(out_valid), 32'd1);
    check("sel_40", 32'(out_sample), 32'd40);
    check("sel_err", 32'(out_err), 32'd0);
    step();

    // Masked error: only slots 0 and 2 participate, target beyond popcount.
    mask = 7'h05; target = RB'(3); ranks = '0;
    ranks[0 +: RB] = RB'(1); ranks[2*int'(RB) +: RB] = RB'(2);
    in_valid = 1; in_sample = 8'd80;
    step(); in_valid = 0; step();
    check("mask_err", 32'(out_err), 32'd1);
    check("mask_err_sample", 32'(out_sample), 32'd0);
    step();
    mask = 7'h7F; set_ranks_seq(); target = '0;
    in_valid = 1; in_sample = 8'd90;
    step(); in_valid = 0; step();
    check("target0_err", 32'(out_err), 32'd1);
    step();

    // Backpressure: result held for 5 cycles, no accepts.
    target = RB'(7); out_ready = 0; in_valid = 1; in_sample = 8'd99;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_shift_en", 32'(shift_en), 32'd0);
      check("bp_hold", 32'(out_sample), 32'd99);
      step();
    end
    in_valid = 0; out_ready = 1;
    step();
    check("bp_consumed", 32'(out_valid), 32'd0);
    step();

    // Streaming: one accept every 2 cycles.
    a0 = m_acc; r0 = m_res_cnt;
    in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      in_sample = W'(i + 100);
      step();
    end
    check("stream_accepts", 32'(m_acc - a0), 32'd10);
    in_valid = 0;
    step(); step(); step();
    check("stream_results", 32'(m_res_cnt - r0), 32'd10);

    // Reset while the selection stage is active.
    in_valid = 1; in_sample = 8'd5;
    step();
    in_valid = 0; rst = 1;
    step();
    rst = 0;
    check("rst_no_out", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_sample = W'(i);
      step();
      check("rst_warmup", 32'(out_valid), 32'd0);
    end
    in_valid = 0;
    step(); step();
    check("rst_warmup_tail", 32'(out_valid), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      randomize_inputs();
      step();
    end
    rst = 0; in_valid = 0; out_ready = 1;
    step(); step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
